latch_write_sched: RTL and testbench

Round-robin scheduler that shares a bank of gated D latches (NAND-built `En`/`D`/`Q` cells) among several write requesters. It captures one request at a time and sequences the latch control pins cleanly: data is set up, the target word's enable is pulsed, then data is held while the enable is low. It sits between the clocked request logic and the latch bank, so no requester ever drives a latch `En` directly.

---
 rtl/latch_write_sched.sv | 140 ++++++++++++++
 tb/tb_latch_write_sched.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/latch_write_sched.sv
// Round-robin write scheduler for a shared bank of gated D latches: setup, enable pulse, hold.
// Optional readback compare is built when LATCH_WRITE_SCHED_VERIFY_EN is defined.
module latch_write_sched #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 8,
    parameter int NLAT      = 4,
    parameter int EN_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NREQ-1:0]               req,
    input  logic [NREQ*$clog2(NLAT)-1:0]  req_addr,
    input  logic [NREQ*WIDTH-1:0]         req_data,
    output logic [NREQ-1:0]               gnt,
    output logic [NREQ-1:0]               ack,
    output logic                          busy,
    output logic [NLAT-1:0]               latch_en,
    output logic [WIDTH-1:0]              latch_d,
    input  logic [NLAT*WIDTH-1:0]         latch_q,
    output logic                          mismatch
);
    localparam int AW = $clog2(NLAT);
    localparam int IW = $clog2(NREQ);
    localparam int CW = 4;

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   ptr, ptr_nx;
    logic [AW-1:0]   addr, addr_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [NREQ-1:0] gnt_nx, ack_nx;
    logic            busy_nx, mismatch_nx;
    logic [NLAT-1:0] latch_en_nx;
    logic [WIDTH-1:0] latch_d_nx;

    logic            found;
    logic [IW-1:0]   sel, cand;
    int unsigned     idx;
    logic            rb_err;

`ifdef LATCH_WRITE_SCHED_VERIFY_EN
    assign rb_err = (latch_q[32'(addr)*WIDTH +: WIDTH] != latch_d);
`else
    logic unused_q;
    assign unused_q = ^latch_q;
    assign rb_err   = 1'b0;
`endif

    // First requester at or after ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        cand  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx  = (32'(ptr) + k) % NREQ;
            cand = IW'(idx);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    // latch_d doubles as the captured-data register; it only moves on SETUP entry.
    always_comb begin
        state_nx    = state;
        ptr_nx      = ptr;
        addr_nx     = addr;
        cnt_nx      = cnt;
        gnt_nx      = gnt;
        ack_nx      = '0;
        busy_nx     = busy;
        latch_en_nx = latch_en;
        latch_d_nx  = latch_d;
        mismatch_nx = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nx    = SETUP;
                    addr_nx     = req_addr[32'(sel)*AW +: AW];
                    latch_d_nx  = req_data[32'(sel)*WIDTH +: WIDTH];
                    gnt_nx      = '0;
                    gnt_nx[sel] = 1'b1;
                    busy_nx     = 1'b1;
                    ptr_nx      = (sel == IW'(NREQ - 1)) ? '0 : IW'(sel + 1'b1);
                end
            end
            SETUP: begin
                state_nx          = PULSE;
                cnt_nx            = CW'(EN_CYCLES - 1);
                latch_en_nx       = '0;
                latch_en_nx[addr] = 1'b1;
            end
            PULSE: begin
                if (cnt == '0) begin
                    state_nx    = HOLD;
                    latch_en_nx = '0;
                    ack_nx      = gnt;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            HOLD: begin
                state_nx    = IDLE;
                gnt_nx      = '0;
                busy_nx     = 1'b0;
                mismatch_nx = rb_err;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            addr     <= '0;
            cnt      <= '0;
            gnt      <= '0;
            ack      <= '0;
            busy     <= 1'b0;
            latch_en <= '0;
            latch_d  <= '0;
            mismatch <= 1'b0;
        end else begin
            state    <= state_nx;
            ptr      <= ptr_nx;
            addr     <= addr_nx;
            cnt      <= cnt_nx;
            gnt      <= gnt_nx;
            ack      <= ack_nx;
            busy     <= busy_nx;
            latch_en <= latch_en_nx;
            latch_d  <= latch_d_nx;
            mismatch <= mismatch_nx;
        end
    end
endmodule

// File: tb/tb_latch_write_sched.sv
// Self-checking bench for latch_write_sched: transaction-timeline model plus directed vectors.
module tb_latch_write_sched;
    localparam int NREQ = 4, WIDTH = 8, NLAT = 4, AW = 2, EN = 2;
`ifdef LATCH_WRITE_SCHED_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b1;
    logic [NREQ-1:0]         req = '0;
    logic [NREQ*AW-1:0]      req_addr = '0;
    logic [NREQ*WIDTH-1:0]   req_data = '0;
    logic [NREQ-1:0]         gnt, ack;
    logic                    busy, mismatch;
    logic [NLAT-1:0]         latch_en;
    logic [WIDTH-1:0]        latch_d;
    logic [NLAT*WIDTH-1:0]   latch_q;

    latch_write_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .NLAT(NLAT), .EN_CYCLES(EN)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_data(req_data),
        .gnt(gnt), .ack(ack), .busy(busy), .latch_en(latch_en), .latch_d(latch_d),
        .latch_q(latch_q), .mismatch(mismatch)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural latch bank: transparent while its enable is high.
    logic [WIDTH-1:0] bank [NLAT] = '{default: '0};
    bit corrupt = 1'b0;
    always @(negedge clk)
        for (int i = 0; i < NLAT; i++) if (latch_en[i]) bank[i] <= latch_d;
    always_comb
        for (int i = 0; i < NLAT; i++)
            latch_q[i*WIDTH +: WIDTH] = (corrupt && i == 0) ? '0 : bank[i];

    // Requester behaviour: drop req once acknowledged.
    always @(negedge clk) if (ack != 0) req = req & ~ack;

    // Model: m_t = cycles since capture (0 = idle), timeline SETUP=1, PULSE=2..EN+1, HOLD=EN+2.
    int m_t = 0, m_g = 0, m_addr = 0, m_ptr = 0;
    logic [WIDTH-1:0] m_data = '0, m_ld = '0;
    bit m_mm = 1'b0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t = 0; m_ptr = 0; m_ld = '0; m_mm = 1'b0;
        end else begin
            m_mm = 1'b0;
            if (m_t == EN + 2) begin
                m_mm = VERIFY && corrupt && m_addr == 0 && m_data != 0;
                m_t = 0;
            end else if (m_t != 0) begin
                m_t++;
            end else if (req != 0) begin
                for (int k = 0; k < NREQ; k++)
                    if (m_t == 0 && req[(m_ptr + k) % NREQ]) begin
                        m_g = (m_ptr + k) % NREQ;
                        m_t = 1;
                    end
                m_addr = int'(req_addr[m_g*AW +: AW]);
                m_data = req_data[m_g*WIDTH +: WIDTH];
                m_ld   = m_data;
                m_ptr  = (m_g + 1) % NREQ;
            end
        end
    end

    bit chk_on = 1'b0;
    logic [NREQ-1:0] e_gnt, e_ack;
    logic [NLAT-1:0] e_en;
    always @(negedge clk) if (chk_on) begin
        e_gnt = (m_t != 0) ? NREQ'(1) << m_g : '0;
        e_ack = (m_t == EN + 2) ? NREQ'(1) << m_g : '0;
        e_en  = (m_t >= 2 && m_t <= EN + 1) ? NLAT'(1) << m_addr : '0;
        check("gnt", gnt, e_gnt);
        check("ack", ack, e_ack);
        check("busy", busy, m_t != 0);
        check("latch_en", latch_en, e_en);
        check("latch_d", latch_d, m_ld);
        check("mismatch", mismatch, m_mm);
    end

    // latch_d must not move while enabled or in the cycle right after an enable cycle.
    logic [WIDTH-1:0] prev_d = '0;
    logic [NLAT-1:0]  prev_en = '0;
    bit have_prev = 1'b0;
    always @(negedge clk) begin
        if (have_prev && rst_n && (latch_en != 0 || prev_en != 0))
            check("setup_hold", latch_d, prev_d);
        prev_d = latch_d; prev_en = latch_en; have_prev = rst_n;
    end

    int mm_cnt = 0;
    always @(negedge clk) if (mismatch) mm_cnt++;

    task automatic wait_drop(input int r, input string name);
        int n = 0;
        while (req[r] && n < 40) begin @(negedge clk); n++; end
        if (req[r]) begin
            n_chk++; n_fail++;
            $display("FAIL %s: no ack within %0d cycles, expected ack", name, n);
            req[r] = 1'b0;
        end
    endtask

    task automatic write(input int r, input int a, input logic [WIDTH-1:0] d);
        @(posedge clk); #1;
        req_addr[r*AW +: AW]   = AW'(a);
        req_data[r*WIDTH +: WIDTH] = d;
        req[r] = 1'b1;
    endtask

    int order[$];
    logic [NREQ-1:0] last_g;
    int n;

    initial begin
        #1 rst_n = 1'b0;
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_ack", ack, 0);
        check("rst_busy", busy, 0);
        check("rst_en", latch_en, 0);
        check("rst_d", latch_d, 0);
        check("rst_mm", mismatch, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        chk_on = 1'b1;

        // Single write: req1, word 2, A5
        write(1, 2, 8'hA5);
        @(posedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            check("sw_gnt", gnt, (c <= 4) ? 4'b0010 : 4'b0000);
            check("sw_en", latch_en, (c == 2 || c == 3) ? 4'b0100 : 4'b0000);
            check("sw_ack", ack, (c == 4) ? 4'b0010 : 4'b0000);
            check("sw_d", latch_d, 8'hA5);
        end
        check("sw_bank", bank[2], 8'hA5);

        // Reset mid-PULSE
        write(0, 3, 8'h5A);
        n = 0;
        while (latch_en == 0 && n < 20) begin @(negedge clk); n++; end
        check("rst_reach_pulse", latch_en != 0, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_en", latch_en, 0);
        check("arst_gnt", gnt, 0);
        check("arst_d", latch_d, 0);
        check("arst_busy", busy, 0);
        req_addr[1*AW +: AW] = 2'd1; req_data[1*WIDTH +: WIDTH] = 8'h11;
        req_addr[3*AW +: AW] = 2'd3; req_data[3*WIDTH +: WIDTH] = 8'h33;
        req = 4'b1011;
        @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;

        // Round-robin: expect 0,1,3 then 0 again
        last_g = '0;
        n = 0;
        while (!(order.size() >= 4 && gnt == 0 && !busy) && n < 100) begin
            @(negedge clk); n++;
            if (gnt != 0 && last_g == 0)
                for (int i = 0; i < NREQ; i++) if (gnt[i]) begin
                    order.push_back(i);
                    if (i == 3) req[0] = 1'b1;
                end
            last_g = gnt;
        end
        check("rr_count", order.size(), 4);
        if (order.size() >= 4) begin
            check("rr_0", order[0], 0);
            check("rr_1", order[1], 1);
            check("rr_2", order[2], 3);
            check("rr_3", order[3], 0);
        end
        req = '0;

        // Random data on req0/req2 (setup/hold checker runs continuously)
        for (int t = 0; t < 6; t++) begin
            int r, a;
            logic [WIDTH-1:0] d;
            r = (t % 2 == 1) ? 2 : 0;
            a = $urandom_range(0, NLAT - 1);
            d = WIDTH'($urandom);
            write(r, a, d);
            wait_drop(r, "rand_ack");
            check("rand_bank", bank[a], d);
        end

        // Input change during PULSE must not affect the written word
        write(2, 1, 8'h3C);
        n = 0;
        while (latch_en == 0 && n < 20) begin @(negedge clk); n++; end
        req_data[2*WIDTH +: WIDTH] = 8'hC3;
        req_addr[2*AW +: AW] = 2'd0;
        wait_drop(2, "chg_ack");
        check("chg_bank", bank[1], 8'h3C);
        check("chg_d", latch_d, 8'h3C);

        // Readback: corrupted word 0, then clean
        mm_cnt = 0;
        corrupt = 1'b1;
        write(0, 0, 8'hFF);
        wait_drop(0, "rb_ack");
        repeat (3) @(negedge clk);
        check("rb_bad", mm_cnt, VERIFY ? 1 : 0);
        corrupt = 1'b0;
        mm_cnt = 0;
        write(0, 0, 8'hFF);
        wait_drop(0, "rb2_ack");
        repeat (3) @(negedge clk);
        check("rb_good", mm_cnt, 0);

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
